// File: rtl/noc_pkg.sv
// Shared NoC types: output-port encoding, flit layout and XY route function.
package noc_pkg;

  localparam int unsigned COORD_W = 4;
  localparam int unsigned DATA_W  = 4;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    EAST  = 3'd2,
    SOUTH = 3'd3,
    WEST  = 3'd4
  } port_e;

  typedef struct packed {
    logic signed [COORD_W-1:0] s_delta_x;
    logic signed [COORD_W-1:0] s_delta_y;
    logic [COORD_W-1:0]        dest_x;
    logic [COORD_W-1:0]        dest_y;
    logic [DATA_W-1:0]         data;
  } flit_t;

  // Signed zero so the deltas are compared as two's complement.
  localparam logic signed [COORD_W-1:0] CoordZero = '0;

  // Dimension-order routing: resolve X first, then Y, else deliver locally.
  function automatic port_e xy_route(flit_t f);
    port_e p;
    if ($signed(f.s_delta_x) > CoordZero) begin
      p = EAST;
    end else if ($signed(f.s_delta_x) < CoordZero) begin
      p = WEST;
    end else if ($signed(f.s_delta_y) > CoordZero) begin
      p = NORTH;
    end else if ($signed(f.s_delta_y) < CoordZero) begin
      p = SOUTH;
    end else begin
      p = LOCAL;
    end
    return p;
  endfunction

endpackage

// File: rtl/router_input_buffer_if.sv
// Upstream/downstream handshake bundle for one router input buffer.
interface router_input_buffer_if #(
  parameter int unsigned DEPTH = 4
);
  import noc_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic signed [COORD_W-1:0] in_s_delta_x;
  logic signed [COORD_W-1:0] in_s_delta_y;
  logic [COORD_W-1:0]        in_dest_x;
  logic [COORD_W-1:0]        in_dest_y;
  logic [DATA_W-1:0]         in_data;

  logic                      out_valid;
  logic                      out_ready;
  logic signed [COORD_W-1:0] out_s_delta_x;
  logic signed [COORD_W-1:0] out_s_delta_y;
  logic [COORD_W-1:0]        out_dest_x;
  logic [COORD_W-1:0]        out_dest_y;
  logic [DATA_W-1:0]         out_data;
  port_e                     out_port;

  logic [$clog2(DEPTH):0]    count;

  // Upstream/environment view.
  modport master (
    output in_valid, in_s_delta_x, in_s_delta_y, in_dest_x, in_dest_y, in_data, out_ready,
    input  in_ready, out_valid, out_s_delta_x, out_s_delta_y, out_dest_x, out_dest_y,
           out_data, out_port, count
  );

  // Buffer view.
  modport slave (
    input  in_valid, in_s_delta_x, in_s_delta_y, in_dest_x, in_dest_y, in_data, out_ready,
    output in_ready, out_valid, out_s_delta_x, out_s_delta_y, out_dest_x, out_dest_y,
           out_data, out_port, count
  );

endinterface

// File: rtl/flit_fifo.sv
// Show-ahead flit FIFO; the head flit is held in a register so it resets to zero.
module flit_fifo import noc_pkg::*; #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_valid,
  output logic          push_ready,
  input  flit_t         push_flit,
  output logic          pop_valid,
  input  logic          pop_ready,
  output flit_t         pop_flit,
  output logic [CW-1:0] count
);

  flit_t         mem_q [DEPTH];
  flit_t         head_q, head_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  // Full/empty come from occupancy, never from pointer comparison.
  assign push_ready = (count_q != CW'(DEPTH));
  assign pop_valid  = (count_q != '0);
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;
  assign pop_flit   = head_q;
  assign count      = count_q;

  // Next pointers, occupancy and head flit.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // The new head is the incoming flit when it lands in the slot being exposed.
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) head_d = push_flit;
      else                                head_d = mem_q[rd_ptr_d];
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_flit;
  end

  // Pointer, occupancy and head registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/router_input_buffer.sv
// Router input port buffer: flit FIFO plus XY route request for the head flit.
module router_input_buffer import noc_pkg::*; #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  router_input_buffer_if.slave  bus_io
);

  flit_t in_flit;
  flit_t head;

  assign in_flit = '{
    s_delta_x: bus_io.in_s_delta_x,
    s_delta_y: bus_io.in_s_delta_y,
    dest_x:    bus_io.in_dest_x,
    dest_y:    bus_io.in_dest_y,
    data:      bus_io.in_data
  };

  flit_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (bus_io.in_valid),
    .push_ready (bus_io.in_ready),
    .push_flit  (in_flit),
    .pop_valid  (bus_io.out_valid),
    .pop_ready  (bus_io.out_ready),
    .pop_flit   (head),
    .count      (bus_io.count)
  );

  assign bus_io.out_s_delta_x = head.s_delta_x;
  assign bus_io.out_s_delta_y = head.s_delta_y;
  assign bus_io.out_dest_x    = head.dest_x;
  assign bus_io.out_dest_y    = head.dest_y;
  assign bus_io.out_data      = head.data;
  assign bus_io.out_port      = xy_route(head);

endmodule

// File: tb/tb_router_input_buffer.sv
// Bench for router_input_buffer: occupancy model plus a flit scoreboard.
module tb_router_input_buffer;
  import noc_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  router_input_buffer_if #(.DEPTH(DEPTH)) bus ();

  router_input_buffer #(
    .DEPTH(DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  int    mcount = 0;
  flit_t sb[$];

  function automatic port_e tb_route(int sdx, int sdy);
    if (sdx > 0) return EAST;
    if (sdx < 0) return WEST;
    if (sdy > 0) return NORTH;
    if (sdy < 0) return SOUTH;
    return LOCAL;
  endfunction

  // Monitor on the falling edge: handshakes seen here complete on the next rising edge.
  always @(negedge clk) begin : mon
    logic  exp_ready, exp_valid, do_push, do_pop;
    flit_t exp_f, got_f, in_f;
    if (rst) begin
      sb.delete();
      mcount = 0;
    end else begin
      exp_ready = (mcount != DEPTH);
      exp_valid = (mcount != 0);
      total++;
      if (bus.count !== CW'(mcount)) begin
        bad++;
        $display("FAIL mon_count: got %0d want %0d", bus.count, mcount);
      end
      total++;
      if (bus.in_ready !== exp_ready) begin
        bad++;
        $display("FAIL mon_in_ready: got %b want %b", bus.in_ready, exp_ready);
      end
      total++;
      if (bus.out_valid !== exp_valid) begin
        bad++;
        $display("FAIL mon_out_valid: got %b want %b", bus.out_valid, exp_valid);
      end
      do_pop  = exp_valid && bus.out_ready;
      do_push = bus.in_valid && exp_ready;
      if (do_pop) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL mon_underflow: got pop want empty scoreboard untouched");
        end else begin
          exp_f = sb.pop_front();
          got_f = '{bus.out_s_delta_x, bus.out_s_delta_y, bus.out_dest_x, bus.out_dest_y,
                    bus.out_data};
          if (got_f !== exp_f) begin
            bad++;
            $display("FAIL mon_head: got %h want %h", got_f, exp_f);
          end
          total++;
          if (bus.out_port !== tb_route($signed(exp_f.s_delta_x), $signed(exp_f.s_delta_y)))
          begin
            bad++;
            $display("FAIL mon_port: got %0d want %0d", bus.out_port,
                     tb_route($signed(exp_f.s_delta_x), $signed(exp_f.s_delta_y)));
          end
        end
      end
      if (do_push) begin
        in_f = '{bus.in_s_delta_x, bus.in_s_delta_y, bus.in_dest_x, bus.in_dest_y, bus.in_data};
        sb.push_back(in_f);
      end
      mcount = mcount + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sdx, input int sdy, input int dx, input int dy, input int d);
    bus.in_valid     = 1'b1;
    bus.in_s_delta_x = COORD_W'(sdx);
    bus.in_s_delta_y = COORD_W'(sdy);
    bus.in_dest_x    = COORD_W'(dx);
    bus.in_dest_y    = COORD_W'(dy);
    bus.in_data      = DATA_W'(d);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_s_delta_x = '0; bus.in_s_delta_y = '0;
    bus.in_dest_x = '0; bus.in_dest_y = '0; bus.in_data = '0;
    rst = 1'b1;
    #2;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.count !== CW'(0)) begin
      bad++;
      $display("FAIL reset_flags: got v=%b r=%b c=%0d want v=0 r=1 c=0",
               bus.out_valid, bus.in_ready, bus.count);
    end
    total++;
    if (bus.out_data !== '0 || bus.out_s_delta_x !== '0 || bus.out_dest_y !== '0 ||
        bus.out_port !== LOCAL) begin
      bad++;
      $display("FAIL reset_fields: got data=%h sdx=%h dy=%h port=%0d want 0 0 0 LOCAL",
               bus.out_data, bus.out_s_delta_x, bus.out_dest_y, bus.out_port);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    drive(2, 0, 3, 1, 'hA);
    tick();
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_port !== EAST || bus.count !== CW'(1)) begin
      bad++;
      $display("FAIL single_head: got v=%b port=%0d c=%0d want v=1 port=EAST c=1",
               bus.out_valid, bus.out_port, bus.count);
    end
    total++;
    if (bus.out_data !== 4'hA || bus.out_dest_x !== 4'd3 || bus.out_dest_y !== 4'd1) begin
      bad++;
      $display("FAIL single_fields: got data=%h dx=%0d dy=%0d want A 3 1",
               bus.out_data, bus.out_dest_x, bus.out_dest_y);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total++;
    if (bus.count !== CW'(0) || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_pop: got c=%0d v=%b want c=0 v=0", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_routing();
    int    sdx_t[5] = '{-1, 0, 0, 0, -8};
    int    sdy_t[5] = '{3, 1, -2, 0, 0};
    port_e exp_t[5] = '{WEST, NORTH, SOUTH, LOCAL, WEST};
    for (int i = 0; i < 5; i++) begin
      drive(sdx_t[i], sdy_t[i], i, 4 - i, i + 1);
      tick();
      bus.in_valid = 1'b0;
      total++;
      if (bus.out_port !== exp_t[i]) begin
        bad++;
        $display("FAIL route_%0d: got %0d want %0d", i, bus.out_port, exp_t[i]);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_fill_stall();
    bus.out_ready = 1'b0;
    for (int d = 1; d <= 5; d++) begin
      drive(1, 0, 0, 0, d);
      tick();
      if (d == 4) begin
        total++;
        if (bus.count !== CW'(4) || bus.in_ready !== 1'b0) begin
          bad++;
          $display("FAIL fill_full: got c=%0d r=%b want c=4 r=0", bus.count, bus.in_ready);
        end
      end
    end
    tick();
    total++;
    if (bus.count !== CW'(4)) begin
      bad++;
      $display("FAIL fill_stall: got c=%0d want 4", bus.count);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int d = 1; d <= 4; d++) begin
      total++;
      if (bus.out_data !== DATA_W'(d)) begin
        bad++;
        $display("FAIL drain_order: got %0d want %0d", bus.out_data, d);
      end
      tick();
    end
    bus.out_ready = 1'b0;
    total++;
    if (bus.count !== CW'(0)) begin
      bad++;
      $display("FAIL drain_empty: got c=%0d want 0", bus.count);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    drive(0, 1, 1, 1, 0);
    tick();
    drive(0, -1, 2, 2, 1);
    tick();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive((i % 3) - 1, 1, i, i, i + 2);
      tick();
      total++;
      if (bus.count !== CW'(2)) begin
        bad++;
        $display("FAIL b2b_count_%0d: got %0d want 2", i, bus.count);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    tick();
    bus.out_ready = 1'b0;
    total++;
    if (bus.count !== CW'(0)) begin
      bad++;
      $display("FAIL b2b_drain: got c=%0d want 0", bus.count);
    end
  endtask

  task automatic test_full_pop();
    bus.out_ready = 1'b0;
    for (int d = 12; d < 16; d++) begin
      drive(-2, 0, 5, 5, d);
      tick();
    end
    drive(3, 0, 6, 6, 5);
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b0 || bus.count !== CW'(4)) begin
      bad++;
      $display("FAIL fullpop_ready: got r=%b c=%0d want r=0 c=4", bus.in_ready, bus.count);
    end
    tick();
    bus.in_valid = 1'b0;
    total++;
    if (bus.count !== CW'(3) || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL fullpop_after: got c=%0d r=%b want c=3 r=1", bus.count, bus.in_ready);
    end
    tick();
    tick();
    tick();
    bus.out_ready = 1'b0;
    total++;
    if (bus.count !== CW'(0)) begin
      bad++;
      $display("FAIL fullpop_drain: got c=%0d want 0", bus.count);
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    for (int d = 7; d < 10; d++) begin
      drive(0, 0, 1, 2, d);
      tick();
    end
    bus.in_valid = 1'b0;
    total++;
    if (bus.count !== CW'(3)) begin
      bad++;
      $display("FAIL arst_pre: got c=%0d want 3", bus.count);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.count !== CW'(0) || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL arst_async: got v=%b c=%0d r=%b want v=0 c=0 r=1",
               bus.out_valid, bus.count, bus.in_ready);
    end
    tick();
    rst = 1'b0;
    drive(0, 2, 3, 3, 6);
    tick();
    drive(0, -3, 4, 4, 5);
    tick();
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_data !== 4'h6 || bus.count !== CW'(2) || bus.out_port !== NORTH) begin
      bad++;
      $display("FAIL arst_first: got data=%h c=%0d port=%0d want 6 2 NORTH",
               bus.out_data, bus.count, bus.out_port);
    end
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_routing();
    test_fill_stall();
    test_back_to_back();
    test_full_pop();
    test_async_reset();
    tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
